vga_tile_grid: RTL and testbench

VGA_TILE_GRID -- requirements
Module: vga_tile_grid

---
 rtl/vga_tile_pkg.sv | 50 +++++
 rtl/vga_timing_gen.sv | 99 +++++++++
 rtl/vga_tile_grid.sv | 134 +++++++++++++
 tb/tb_vga_tile_grid.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_tile_pkg.sv
// rtl/vga_tile_pkg.sv - shared timing defaults, pipeline flag struct and width helpers
package vga_tile_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLS     = 4;
    localparam int DEF_ROWS     = 2;
    localparam int DEF_CW       = 3;

    // Per-pixel flags carried from stage 1 to stage 2
    typedef struct packed {
        logic vis;
        logic grid;
        logic hsync_n;
        logic vsync_n;
    } pix_flags_t;

    // Total clocks (or lines) of one period: active + front porch + sync + back porch
    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    // Bits for a counter spanning 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Tile address width: wide enough that the first out-of-range index (n) is expressible,
    // so an illegal write can actually be presented and flagged
    function automatic int addr_width(input int tiles);
        return clog2(tiles + 1);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - stage-0 pixel/line counters, tile sub-counters and sync decode
module vga_timing_gen
    import vga_tile_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int IW       = addr_width(DEF_COLS * DEF_ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx,
    output logic          vis,
    output logic          tile_edge,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          commit
);

    localparam int H_TOTAL   = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL   = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW        = cnt_width(H_TOTAL);
    localparam int VW        = cnt_width(V_TOTAL);
    localparam int TW        = H_ACTIVE / COLS;
    localparam int TH        = V_ACTIVE / ROWS;
    localparam int XW        = cnt_width(TW);
    localparam int YW        = cnt_width(TH);
    localparam int CLW       = cnt_width(COLS);
    localparam int LAST_BASE = (ROWS - 1) * COLS;
    localparam int HS_START  = H_ACTIVE + H_FP;
    localparam int HS_END    = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_START  = V_ACTIVE + V_FP;
    localparam int VS_END    = V_ACTIVE + V_FP + V_SYNC - 1;

    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    logic [XW-1:0]  xsub;
    logic [YW-1:0]  ysub;
    logic [CLW-1:0] tcol;
    logic [IW-1:0]  row_base;
    logic           h_last;
    logic           v_last;

    assign h_last = (hcnt == HW'(H_TOTAL - 1));
    assign v_last = (vcnt == VW'(V_TOTAL - 1));

    // Raster counters; the tile column and the row base (row*COLS) advance by counting
    // pixels/lines within a tile, so no divider or multiplier sits on the pixel path
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt     <= '0;
            vcnt     <= '0;
            xsub     <= '0;
            tcol     <= '0;
            ysub     <= '0;
            row_base <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            xsub <= '0;
            tcol <= '0;
            if (v_last) begin
                vcnt     <= '0;
                ysub     <= '0;
                row_base <= '0;
            end else begin
                vcnt <= vcnt + VW'(1);
                if (ysub == YW'(TH - 1)) begin
                    ysub <= '0;
                    if (row_base != IW'(LAST_BASE)) row_base <= row_base + IW'(COLS);
                end else begin
                    ysub <= ysub + YW'(1);
                end
            end
        end else begin
            hcnt <= hcnt + HW'(1);
            if (xsub == XW'(TW - 1)) begin
                xsub <= '0;
                if (tcol != CLW'(COLS - 1)) tcol <= tcol + CLW'(1);
            end else begin
                xsub <= xsub + XW'(1);
            end
        end
    end

    assign idx       = row_base + IW'(tcol);
    assign vis       = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    assign tile_edge = (xsub == '0) || (ysub == '0);
    assign hsync_n   = !((hcnt >= HW'(HS_START)) && (hcnt <= HW'(HS_END)));
    assign vsync_n   = !((vcnt >= VW'(VS_START)) && (vcnt <= VW'(VS_END)));
    assign commit    = h_last && (vcnt == VW'(V_ACTIVE - 1));

endmodule

// File: rtl/vga_tile_grid.sv
// rtl/vga_tile_grid.sv - tile-colour VGA generator with double-buffered tile banks
module vga_tile_grid
    import vga_tile_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int CW       = DEF_CW,
    parameter logic [CW-1:0] GRID_COLOR = '1,
    localparam int NT = COLS * ROWS,
    localparam int AW = addr_width(NT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_data,
    output logic          wr_err,
    input  logic          grid_en,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          de,
    output logic [CW-1:0] rgb,
    output logic          frame_done
);

    logic          run;
    logic          accept;
    logic          bad_addr;
    logic          commit;
    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
    logic          vis0;
    logic          edge0;
    logic          hs0;
    logic          vs0;
    pix_flags_t    flags1;
    logic [CW-1:0] shadow [NT];
    logic [CW-1:0] active [NT];
    logic [CW-1:0] tile_color;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .COLS     (COLS),
        .ROWS     (ROWS),
        .IW       (AW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx0),
        .vis       (vis0),
        .tile_edge (edge0),
        .hsync_n   (hs0),
        .vsync_n   (vs0),
        .commit    (commit)
    );

    // The commit cycle owns the banks, so writes stall there and land one clock later
    assign wr_ready   = run & ~commit;
    assign accept     = wr_valid & wr_ready;
    assign bad_addr   = (wr_addr >= AW'(NT));
    assign frame_done = commit;

    // Write port into shadow, error flag, and shadow-to-active copy at end of visible frame
    always_ff @(posedge clk) begin
        if (rst) begin
            run    <= 1'b0;
            wr_err <= 1'b0;
            for (int i = 0; i < NT; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            run    <= 1'b1;
            wr_err <= accept & bad_addr;
            for (int i = 0; i < NT; i++) begin
                if (accept && (wr_addr == AW'(i))) shadow[i] <= wr_data;
                if (commit) active[i] <= shadow[i];
            end
        end
    end

    // Stage 1: register tile index, visibility, grid hit and raw syncs
    always_ff @(posedge clk) begin
        if (rst) begin
            idx1   <= '0;
            flags1 <= '{vis: 1'b0, grid: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};
        end else begin
            idx1   <= idx0;
            flags1 <= '{vis: vis0, grid: grid_en & edge0, hsync_n: hs0, vsync_n: vs0};
        end
    end

    // Active-bank lookup for the stage-1 tile index
    always_comb begin
        tile_color = '0;
        for (int i = 0; i < NT; i++) begin
            if (idx1 == AW'(i)) tile_color = active[i];
        end
    end

    // Stage 2: registered pixel outputs, black outside the visible area
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb     <= '0;
            de      <= 1'b0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else begin
            de      <= flags1.vis;
            hsync_n <= flags1.hsync_n;
            vsync_n <= flags1.vsync_n;
            if (!flags1.vis)      rgb <= '0;
            else if (flags1.grid) rgb <= GRID_COLOR;
            else                  rgb <= tile_color;
        end
    end

endmodule

// File: tb/tb_vga_tile_grid.sv
// tb/tb_vga_tile_grid.sv - directed self-checking bench for vga_tile_grid on a reduced raster
module tb_vga_tile_grid;

    localparam int HT = 24;
    localparam int VT = 13;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [2:0] wr_data;
    logic       wr_err;
    logic       grid_en;
    logic       hsync_n;
    logic       vsync_n;
    logic       de;
    logic [2:0] rgb;
    logic       frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    int cyc  = 0;
    bit live = 1'b0;
    bit g1   = 1'b0;
    bit g2   = 1'b0;
    logic [2:0] shadow_m [8];
    logic [2:0] active_m [8];
    logic [2:0] pend_m   [8];
    int mp, mx, my, mtile, mexp;

    vga_tile_grid #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
        .COLS (4), .ROWS (2), .CW (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .grid_en    (grid_en),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .de         (de),
        .rgb        (rgb),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_commit(input int n);
        return ((n % HT) == HT - 1) && (((n / HT) % VT) == 7);
    endfunction

    // Stage-0 cycle count since reset release, grid history and reset of the bank model
    always @(posedge clk) begin
        g2 = g1;
        g1 = grid_en;
        if (rst) begin
            live = 1'b0;
            cyc  = 0;
            for (int i = 0; i < 8; i++) begin
                shadow_m[i] = '0;
                active_m[i] = '0;
                pend_m[i]   = '0;
            end
        end else if (!live) begin
            live = 1'b1;
            cyc  = 1;
        end else begin
            cyc++;
        end
    end

    // Every cycle: reset values, or the pixel two clocks behind the stage-0 position
    always @(negedge clk) begin
        if (!live) begin
            chk("rst_hsync_n", hsync_n, 1);
            chk("rst_vsync_n", vsync_n, 1);
            chk("rst_de", de, 0);
            chk("rst_rgb", rgb, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_wr_err", wr_err, 0);
            chk("rst_frame_done", frame_done, 0);
        end else begin
            mp = cyc - 2;
            if (mp >= 0 && is_commit(mp)) active_m = pend_m;
            if (is_commit(cyc)) pend_m = shadow_m;
            chk("wr_ready", wr_ready, is_commit(cyc) ? 0 : 1);
            chk("frame_done", frame_done, is_commit(cyc) ? 1 : 0);
            if (mp < 0) begin
                chk("pipe_hsync_n", hsync_n, 1);
                chk("pipe_vsync_n", vsync_n, 1);
                chk("pipe_de", de, 0);
                chk("pipe_rgb", rgb, 0);
            end else begin
                mx = mp % HT;
                my = (mp / HT) % VT;
                chk("hsync_n", hsync_n, (mx >= 18 && mx <= 20) ? 0 : 1);
                chk("vsync_n", vsync_n, (my >= 9 && my <= 10) ? 0 : 1);
                chk("de", de, (mx < 16 && my < 8) ? 1 : 0);
                if (mx < 16 && my < 8) begin
                    mtile = (my / 4) * 4 + mx / 4;
                    mexp  = (g2 && ((mx % 4) == 0 || (my % 4) == 0)) ? 7 : int'(active_m[mtile]);
                end else begin
                    mexp = 0;
                end
                chk("rgb", rgb, mexp);
            end
        end
    end

    task automatic wait_cycle(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_cycle", cyc, t);
    endtask

    task automatic do_write(input int addr, input int data, input bit exp_err,
                            output int acc_cyc, output int stalls);
        bit done;
        logic [3:0] a4;
        logic [2:0] d3;
        done    = 1'b0;
        stalls  = 0;
        acc_cyc = -1;
        a4 = addr[3:0];
        d3 = data[2:0];
        wr_valid = 1'b1;
        wr_addr  = a4;
        wr_data  = d3;
        for (int k = 0; k < 8 && !done; k++) begin
            if (wr_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
                if (!exp_err) shadow_m[a4[2:0]] = d3;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        chk("wr_accepted", done, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("wr_err_pulse", wr_err, exp_err);
        @(negedge clk);
        chk("wr_err_clear", wr_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, stl, hcount, hfirst;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        grid_en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        wait_cycle(1);
        chk("ready_after_release", wr_ready, 1);

        hcount = 0;
        hfirst = -1;
        wait_cycle(2);
        for (int k = 0; k < 24; k++) begin
            if (!hsync_n) begin
                hcount++;
                if (hfirst < 0) hfirst = cyc;
            end
            @(negedge clk);
        end
        chk("hsync_low_len", hcount, 3);
        chk("hsync_first_low", hfirst, 20);
        wait_cycle(44);
        chk("hsync_line2", hsync_n, 0);

        wait_cycle(48);
        do_write(5, 5, 1'b0, acc, stl);
        wait_cycle(127);
        chk("tile5_cur_frame", rgb, 0);
        wait_cycle(191);
        chk("commit_done", frame_done, 1);
        chk("commit_ready", wr_ready, 0);
        wait_cycle(192);
        chk("done_one_clock", frame_done, 0);
        wait_cycle(217);
        chk("vsync_y8", vsync_n, 1);
        wait_cycle(218);
        chk("vsync_y9", vsync_n, 0);
        wait_cycle(265);
        chk("vsync_y10", vsync_n, 0);
        wait_cycle(266);
        chk("vsync_y11", vsync_n, 1);
        wait_cycle(439);
        chk("tile5_next_frame", rgb, 5);

        wait_cycle(503);
        chk("stall_done", frame_done, 1);
        do_write(2, 3, 1'b0, acc, stl);
        chk("stall_cycles", stl, 1);
        chk("stall_accept_cyc", acc, 504);
        wait_cycle(659);
        chk("tile2_frame2", rgb, 0);
        wait_cycle(971);
        chk("tile2_frame3", rgb, 3);

        wait_cycle(1000);
        do_write(9, 6, 1'b1, acc, stl);
        wait_cycle(1010);
        do_write(8, 2, 1'b1, acc, stl);
        wait_cycle(1020);
        do_write(7, 1, 1'b0, acc, stl);
        wait_cycle(1275);
        chk("tile0_after_bad", rgb, 0);
        wait_cycle(1279);
        chk("tile1_after_bad", rgb, 0);
        wait_cycle(1383);
        chk("tile7_boundary", rgb, 1);

        wait_cycle(1560);
        grid_en = 1'b1;
        wait_cycle(1562);
        chk("grid_x0_y0", rgb, 7);
        wait_cycle(1595);
        chk("tile2_frame5", rgb, 3);
        wait_cycle(1618);
        chk("grid_x8", rgb, 7);
        wait_cycle(1667);
        chk("grid_y4", rgb, 7);
        wait_cycle(1687);
        chk("tile5_frame5", rgb, 5);
        wait_cycle(1695);
        chk("tile7_off_grid", rgb, 1);

        wait_cycle(1980);
        do_write(3, 2, 1'b0, acc, stl);
        wait_cycle(1992);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_de", de, 0);
        chk("midrst_ready", wr_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        wait_cycle(1);
        chk("restart_ready", wr_ready, 1);
        wait_cycle(2);
        chk("restart_grid_origin", rgb, 7);
        wait_cycle(20);
        chk("restart_hsync", hsync_n, 0);
        wait_cycle(127);
        chk("restart_tile5_cleared", rgb, 0);
        wait_cycle(351);
        chk("discarded_write_tile3", rgb, 0);
        wait_cycle(640);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
